feature_serializer: RTL

FEATURE_SERIALIZER -- requirements
Module: feature_serializer

---
 rtl/feature_serializer.sv | 63 ++++++
 1 files changed

// File: rtl/feature_serializer.sv
// feature_serializer: buffers one feature frame and streams it serially to a dense layer
module feature_serializer #(
  parameter int VECTOR_SIZE = 169,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     frame_valid,
  output logic                     ready,
  output logic                     dense_start,
  output logic signed [DATA_W-1:0] feature_out,
  input  logic                     dense_done,
  output logic                     frame_done
);
  typedef enum logic [1:0] {S_LOAD, S_START, S_STREAM, S_WAIT} state_t;
  localparam logic [7:0] LAST = 8'(VECTOR_SIZE - 1);
  state_t state;
  logic [7:0] idx;
  logic signed [DATA_W-1:0] mem [VECTOR_SIZE];
  always_ff @(posedge clk)
    if (state == S_LOAD && wr_en && wr_addr <= LAST) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= S_LOAD;
      idx         <= '0;
      ready       <= 1'b1;
      dense_start <= 1'b0;
      feature_out <= '0;
      frame_done  <= 1'b0;
    end else begin
      dense_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_LOAD: if (frame_valid) begin
          state       <= S_START;
          ready       <= 1'b0;
          dense_start <= 1'b1;
        end
        S_START: begin
          state       <= S_STREAM;
          idx         <= '0;
          feature_out <= mem[0];
        end
        S_STREAM: if (idx == LAST) begin
          state       <= S_WAIT;
          feature_out <= '0;
        end else begin
          idx         <= idx + 8'd1;
          feature_out <= mem[idx + 8'd1];
        end
        S_WAIT: if (dense_done) begin
          state      <= S_LOAD;
          ready      <= 1'b1;
          frame_done <= 1'b1;
          idx        <= '0;
        end
        default: state <= S_LOAD;
      endcase
    end
endmodule
